pwr_wakeup_sched: RTL and testbench

Wakeup and sleep request scheduler in the always-on domain of the power controller. It collects M asynchronous-free (already synchronized) wakeup sources and a software sleep command. It arbitrates among them and drives the level wakeup/sleep request inputs of the PD1/PD2 power FSMs, one operation at a time. It tracks completion through the domain status feedback, enforces a programmable timeout, and records wake causes and errors for the register file.

---
 rtl/pwr_wakeup_sched.sv | 195 +++++++++++++++++++
 tb/tb_pwr_wakeup_sched.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/pwr_wakeup_sched.sv
// Always-on wakeup/sleep scheduler: arbitrates wakeup sources and the software sleep
// command, drives one level request to the PD1/PD2 power FSMs at a time and tracks completion.
module pwr_wakeup_sched #(
  parameter int M     = 4,
  parameter int CNT_W = 8
) (
  input  logic                 i_aon_clk,
  input  logic                 i_soc_pwr_on_rst_n,
  input  logic [M-1:0]         i_wakeup_src,
  input  logic [M-1:0]         i_wakeup_en,
  input  logic [M-1:0]         i_wakeup_map,
  input  logic                 i_sleep_cmd,
  input  logic                 i_pd1_status,
  input  logic                 i_pd2_status,
  input  logic [CNT_W-1:0]     i_timeout_val,
  input  logic [M-1:0]         i_cause_clr,
  input  logic                 i_err_clr,
  output logic                 o_wakeup_req_1,
  output logic                 o_wakeup_req_2,
  output logic                 o_sleep_req,
  output logic [M-1:0]         o_pending,
  output logic [M-1:0]         o_wake_cause,
  output logic [$clog2(M)-1:0] o_grant_id,
  output logic                 o_busy,
  output logic                 o_timeout_err,
  output logic                 o_sleep_abort
);

  localparam int GW = $clog2(M);
  localparam logic [M-1:0] ONE = {{(M-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_WAKE_WAIT, S_SLEEP_WAIT} state_t;

  state_t           r_state;
  logic [M-1:0]     r_src_q;
  logic [M-1:0]     r_pending;
  logic [M-1:0]     r_cause;
  logic             r_sleep_pend;
  logic [CNT_W-1:0] r_cnt;
  logic             r_tgt_pd2;
  logic [GW-1:0]    r_grant_id;
  logic             r_req1;
  logic             r_req2;
  logic             r_sleep_req;
  logic             r_busy;
  logic             r_timeout_err;
  logic             r_sleep_abort;

  logic [M-1:0]     w_rise;
  logic [GW-1:0]    w_sel;
  logic             w_any_pend;
  logic             w_sel_status;
  logic             w_tgt_status;
  logic             w_expire;
  logic [M-1:0]     w_pend_clr;
  logic [M-1:0]     w_cause_set;
  logic             w_to_set;
  logic             w_sleep_clr;
  logic             w_abort;

  assign w_rise       = i_wakeup_src & ~r_src_q & i_wakeup_en;
  assign w_any_pend   = |r_pending;
  assign w_sel_status = i_wakeup_map[w_sel] ? i_pd2_status : i_pd1_status;
  assign w_tgt_status = r_tgt_pd2 ? i_pd2_status : i_pd1_status;
  // A loaded value of 0 never reaches 1, so T = 0 waits forever.
  assign w_expire     = (r_cnt == CNT_W'(1));

  always_comb begin
    w_sel = '0;
    for (int i = M - 1; i >= 0; i--) begin
      if (r_pending[i]) w_sel = GW'(i);
    end
  end

  always_comb begin
    w_pend_clr  = '0;
    w_cause_set = '0;
    w_to_set    = 1'b0;
    w_sleep_clr = 1'b0;
    w_abort     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_any_pend && w_sel_status) begin
          w_pend_clr  = ONE << w_sel;
          w_cause_set = ONE << w_sel;
        end
      end
      S_WAKE_WAIT: begin
        if (w_tgt_status) begin
          w_pend_clr  = ONE << r_grant_id;
          w_cause_set = ONE << r_grant_id;
        end else if (w_expire) begin
          w_pend_clr = ONE << r_grant_id;
          w_to_set   = 1'b1;
        end
      end
      S_SLEEP_WAIT: begin
        if (|w_rise) begin
          w_sleep_clr = 1'b1;
          w_abort     = 1'b1;
        end else if (!i_pd1_status) begin
          w_sleep_clr = 1'b1;
        end else if (w_expire) begin
          w_sleep_clr = 1'b1;
          w_to_set    = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Bookkeeping: in every same-cycle set/clear race the set wins.
  always_ff @(posedge i_aon_clk) begin
    if (!i_soc_pwr_on_rst_n) begin
      r_src_q       <= '0;
      r_pending     <= '0;
      r_cause       <= '0;
      r_timeout_err <= 1'b0;
      r_sleep_pend  <= 1'b0;
    end else begin
      r_src_q       <= i_wakeup_src;
      r_pending     <= (r_pending & ~w_pend_clr) | w_rise;
      r_cause       <= (r_cause & ~i_cause_clr) | w_cause_set;
      r_timeout_err <= (r_timeout_err & ~i_err_clr) | w_to_set;
      r_sleep_pend  <= (r_sleep_pend & ~w_sleep_clr) | i_sleep_cmd;
    end
  end

  always_ff @(posedge i_aon_clk) begin
    if (!i_soc_pwr_on_rst_n) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_tgt_pd2     <= 1'b0;
      r_grant_id    <= '0;
      r_req1        <= 1'b0;
      r_req2        <= 1'b0;
      r_sleep_req   <= 1'b0;
      r_busy        <= 1'b0;
      r_sleep_abort <= 1'b0;
    end else begin
      r_sleep_abort <= w_abort;
      case (r_state)
        S_IDLE: begin
          if (w_any_pend) begin
            r_grant_id <= w_sel;
            if (!w_sel_status) begin
              r_cnt     <= i_timeout_val;
              r_tgt_pd2 <= i_wakeup_map[w_sel];
              r_req1    <= ~i_wakeup_map[w_sel];
              r_req2    <= i_wakeup_map[w_sel];
              r_busy    <= 1'b1;
              r_state   <= S_WAKE_WAIT;
            end
          end else if (r_sleep_pend) begin
            r_cnt       <= i_timeout_val;
            r_sleep_req <= 1'b1;
            r_busy      <= 1'b1;
            r_state     <= S_SLEEP_WAIT;
          end
        end
        S_WAKE_WAIT: begin
          if (w_tgt_status || w_expire) begin
            r_req1  <= 1'b0;
            r_req2  <= 1'b0;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        S_SLEEP_WAIT: begin
          if (w_sleep_clr) begin
            r_sleep_req <= 1'b0;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end else if (r_cnt != '0) begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wakeup_req_1 = r_req1;
  assign o_wakeup_req_2 = r_req2;
  assign o_sleep_req    = r_sleep_req;
  assign o_pending      = r_pending;
  assign o_wake_cause   = r_cause;
  assign o_grant_id     = r_grant_id;
  assign o_busy         = r_busy;
  assign o_timeout_err  = r_timeout_err;
  assign o_sleep_abort  = r_sleep_abort;

endmodule

// File: tb/tb_pwr_wakeup_sched.sv
// Directed bench for pwr_wakeup_sched: every output change is predicted as a
// (cycle, output snapshot) pair and matched in order by a negedge monitor.
module tb_pwr_wakeup_sched;

  localparam int M     = 4;
  localparam int CNT_W = 8;

  logic             clk;
  logic             rst_n;
  logic [M-1:0]     src, en, map, cause_clr;
  logic             sleep_cmd, pd1, pd2, err_clr;
  logic [CNT_W-1:0] tval;
  logic             req1, req2, sreq, busy, terr, abrt;
  logic [M-1:0]     pend, cause;
  logic [1:0]       gid;

  pwr_wakeup_sched #(.M(M), .CNT_W(CNT_W)) dut (
    .i_aon_clk(clk), .i_soc_pwr_on_rst_n(rst_n),
    .i_wakeup_src(src), .i_wakeup_en(en), .i_wakeup_map(map),
    .i_sleep_cmd(sleep_cmd), .i_pd1_status(pd1), .i_pd2_status(pd2),
    .i_timeout_val(tval), .i_cause_clr(cause_clr), .i_err_clr(err_clr),
    .o_wakeup_req_1(req1), .o_wakeup_req_2(req2), .o_sleep_req(sreq),
    .o_pending(pend), .o_wake_cause(cause), .o_grant_id(gid),
    .o_busy(busy), .o_timeout_err(terr), .o_sleep_abort(abrt)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int checks = 0;
  int errors = 0;

  // snapshot: {req1, req2, sleep_req, busy, timeout_err, abort, pending, cause, grant_id}
  function automatic logic [15:0] pack(input logic r1, r2, sr, b, te, ab,
                                       input logic [3:0] p, c, input logic [1:0] g);
    return {r1, r2, sr, b, te, ab, p, c, g};
  endfunction

  // model of expected outputs, edited by the stimulus as it predicts each change
  logic       m_req1 = 0, m_req2 = 0, m_sreq = 0, m_busy = 0, m_err = 0, m_abort = 0;
  logic [3:0] m_pend = 0, m_cause = 0;
  logic [1:0] m_gid = 0;

  logic [47:0] exp_q[$];
  logic        mon_en = 1'b0;
  logic [15:0] prev = '0;

  task automatic push(input logic [31:0] at);
    exp_q.push_back({at, pack(m_req1, m_req2, m_sreq, m_busy, m_err, m_abort, m_pend, m_cause, m_gid)});
  endtask

  task automatic zero_model();
    m_req1 = 0; m_req2 = 0; m_sreq = 0; m_busy = 0; m_err = 0; m_abort = 0;
    m_pend = 0; m_cause = 0; m_gid = 0;
  endtask

  // scoreboard monitor
  always @(negedge clk) begin
    logic [15:0] snap;
    logic [47:0] e;
    if (mon_en) begin
      snap = pack(req1, req2, sreq, busy, terr, abrt, pend, cause, gid);
      if (snap !== prev) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_change cyc=%0d got=%h required=no change", cyc, snap);
        end else begin
          e = exp_q.pop_front();
          if ({cyc[31:0], snap} !== e)
            begin
              errors++;
              $display("FAIL out_change got cyc=%0d snap=%h required cyc=%0d snap=%h",
                       cyc, snap, e[47:16], e[15:0]);
            end
        end
        prev = snap;
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0h required=%0h", name, got, req);
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_reqs"}, {29'd0, req1, req2, sreq}, 32'd0);
    check({tag, "_busy_err_abort"}, {29'd0, busy, terr, abrt}, 32'd0);
    check({tag, "_pending"}, {28'd0, pend}, 32'd0);
    check({tag, "_cause"}, {28'd0, cause}, 32'd0);
    check({tag, "_grant_id"}, {30'd0, gid}, 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    rst_n = 0; src = 4'b1010; en = 4'b0010; map = 4'b0000; cause_clr = 0;
    sleep_cmd = 0; pd1 = 1; pd2 = 0; err_clr = 0; tval = 0;
    step(3);
    check_all_zero("reset");

    // source 1 high at release, PD1 already on; source 3 masked
    mon_en = 1; rst_n = 1; c = cyc;
    m_pend = 4'b0010; push(c + 1);
    m_pend = 0; m_cause = 4'b0010; m_gid = 1; push(c + 2);
    step(3);
    src = 0; en = 4'b1111; cause_clr = 4'b0010; c = cyc;
    m_cause = 0; push(c + 1);
    step(1); cause_clr = 0; step(1);

    // source 2 -> PD1, status arrives in the third wait cycle
    pd1 = 0; tval = 10; map = 4'b0000; src = 4'b0100; c = cyc;
    m_pend = 4'b0100; push(c + 1);
    m_gid = 2; m_req1 = 1; m_busy = 1; push(c + 2);
    m_req1 = 0; m_busy = 0; m_pend = 0; m_cause = 4'b0100; push(c + 5);
    step(4); pd1 = 1; step(3);
    src = 0; cause_clr = 4'b0100; c = cyc;
    m_cause = 0; push(c + 1);
    step(1); cause_clr = 0; step(1);

    // sources 0 and 3 -> PD2 together, T = 0 waits indefinitely
    map = 4'b1001; pd2 = 0; tval = 0; src = 4'b1001; c = cyc;
    m_pend = 4'b1001; push(c + 1);
    m_gid = 0; m_req2 = 1; m_busy = 1; push(c + 2);
    m_req2 = 0; m_busy = 0; m_pend = 4'b1000; m_cause = 4'b0001; push(c + 8);
    m_pend = 0; m_cause = 4'b1001; m_gid = 3; push(c + 9);
    step(7); pd2 = 1; step(4);
    src = 0; cause_clr = 4'b1111; c = cyc;
    m_cause = 0; push(c + 1);
    step(1); cause_clr = 0; step(1);

    // sleep with T = 5 while PD1 stays on -> timeout
    tval = 5; sleep_cmd = 1; c = cyc;
    m_sreq = 1; m_busy = 1; push(c + 2);
    m_sreq = 0; m_busy = 0; m_err = 1; push(c + 7);
    step(1); sleep_cmd = 0; step(8);
    err_clr = 1; c = cyc;
    m_err = 0; push(c + 1);
    step(1); err_clr = 0; step(1);

    // sleep aborted by source 1 (mapped to PD2)
    tval = 0; map = 4'b0010; pd2 = 0; sleep_cmd = 1; c = cyc;
    m_sreq = 1; m_busy = 1; push(c + 2);
    m_sreq = 0; m_busy = 0; m_abort = 1; m_pend = 4'b0010; push(c + 5);
    m_abort = 0; m_gid = 1; m_req2 = 1; m_busy = 1; push(c + 6);
    m_req2 = 0; m_busy = 0; m_pend = 0; m_cause = 4'b0010; push(c + 9);
    step(1); sleep_cmd = 0; step(3);
    src = 4'b0010; step(4); pd2 = 1; step(3);

    // wakeup timeout: source 0 -> PD1 with T = 3, PD1 never comes up
    src = 4'b0011; pd1 = 0; tval = 3; c = cyc;
    m_pend = 4'b0001; push(c + 1);
    m_gid = 0; m_req1 = 1; m_busy = 1; push(c + 2);
    m_req1 = 0; m_busy = 0; m_pend = 0; m_err = 1; push(c + 5);
    step(7);
    err_clr = 1; c = cyc;
    m_err = 0; push(c + 1);
    step(1); err_clr = 0; src = 0; step(1);

    // reset asserted during WAKE_WAIT
    map = 0; tval = 0; src = 4'b0100; c = cyc;
    m_pend = 4'b0100; push(c + 1);
    m_gid = 2; m_req1 = 1; m_busy = 1; push(c + 2);
    step(4);
    rst_n = 0;
    zero_model(); push(c + 5);
    step(2);
    check_all_zero("mid_reset");
    src = 0; rst_n = 1;
    step(6);
    check_all_zero("post_release");

    check("exp_q_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
